// File: rtl/vga_scan_driver.sv
// vga_scan_driver: VGA raster timing generator with pixel-clock divider,
// clamped x/y coordinate stream for the pixel generators and a single
// registered output stage that keeps colour, sync and blank aligned.
module vga_scan_driver #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [8:0] y,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // A one-clock divider still needs a 1-bit register to stay legal.
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W:0]   DIV_HALF = (DIV_W + 1)'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] X_MAX    = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [8:0] Y_MAX    = 9'(V_ACTIVE - 1);

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_next_s;
  logic             tick_s;
  logic             vga_clk_next_s;
  logic [9:0]       h_cnt_r;
  logic [9:0]       v_cnt_r;
  logic             h_last_s;
  logic             v_last_s;
  logic             active_s;
  logic             hsync_raw_s;
  logic             vsync_raw_s;

  // No sync-on-green: the DAC sync pin is permanently low.
  assign VGA_SYNC_N = 1'b0;

  // Divider terminal count defines the pixel tick; VGA_CLK is decoded from the next divider value.
  always_comb begin
    tick_s = (div_r == DIV_LAST);
    if (tick_s) begin
      div_next_s = {DIV_W{1'b0}};
    end else begin
      div_next_s = div_r + DIV_ONE;
    end
    if (CLK_DIV == 1) begin
      vga_clk_next_s = 1'b1;
    end else begin
      vga_clk_next_s = ({1'b0, div_next_s} < DIV_HALF);
    end
  end

  // Raster decode: visible window, sync windows and clamped generator coordinates.
  always_comb begin
    h_last_s    = (h_cnt_r == H_LAST);
    v_last_s    = (v_cnt_r == V_LAST);
    active_s    = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    hsync_raw_s = !((h_cnt_r >= HS_START) && (h_cnt_r < HS_END));
    vsync_raw_s = !((v_cnt_r >= VS_START) && (v_cnt_r < VS_END));
    if (h_cnt_r < H_ACT) begin
      x = h_cnt_r;
    end else begin
      x = X_MAX;
    end
    if (v_cnt_r < V_ACT) begin
      y = v_cnt_r[8:0];
    end else begin
      y = Y_MAX;
    end
  end

  // Pixel clock divider and registered DAC clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r   <= {DIV_W{1'b0}};
      VGA_CLK <= 1'b1;
    end else begin
      div_r   <= div_next_s;
      VGA_CLK <= vga_clk_next_s;
    end
  end

  // Horizontal and vertical raster counters, advancing only on the pixel tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else if (tick_s) begin
      if (h_last_s) begin
        h_cnt_r <= 10'd0;
        if (v_last_s) begin
          v_cnt_r <= 10'd0;
        end else begin
          v_cnt_r <= v_cnt_r + 10'd1;
        end
      end else begin
        h_cnt_r <= h_cnt_r + 10'd1;
      end
    end
  end

  // Single output stage so colour, syncs and blank share exactly one tick of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      VGA_R       <= 8'd0;
      VGA_G       <= 8'd0;
      VGA_B       <= 8'd0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else if (tick_s) begin
      VGA_R       <= active_s ? r : 8'd0;
      VGA_G       <= active_s ? g : 8'd0;
      VGA_B       <= active_s ? b : 8'd0;
      VGA_HS      <= hsync_raw_s;
      VGA_VS      <= vsync_raw_s;
      VGA_BLANK_N <= active_s;
    end
  end

  // One-clock frame marker following the tick that shows pixel (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick_s && (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
    end
  end

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver: three instances (small raster /2, small raster /4,
// full 640x480 /2) checked every clock against a tick-count raster model.
module tb_vga_scan_driver;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n;
  bit started = 1'b0;
  bit phase1 = 1'b0;

  // instance A: 16x8 visible, CLK_DIV=2 ; B: same raster, CLK_DIV=4 ; C: default
  logic [9:0] a_x, b_x, c_x;
  logic [8:0] a_y, b_y, c_y;
  logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
  logic [7:0] a_R, a_G, a_B, b_R, b_G, b_B, c_R, c_G, c_B;
  logic a_hs, a_vs, a_bn, a_sn, a_vc, a_fs;
  logic b_hs, b_vs, b_bn, b_sn, b_vc, b_fs;
  logic c_hs, c_vs, c_bn, c_sn, c_vc, c_fs;

  assign a_r = a_x[7:0];
  assign a_g = a_y[7:0];
  assign a_b = 8'hC3;
  assign b_r = 8'hFF;
  assign b_g = 8'h00;
  assign b_b = b_x[7:0] ^ b_y[7:0];
  assign c_r = c_x[7:0];
  assign c_g = c_y[7:0];
  assign c_b = 8'h5A;

  vga_scan_driver #(.CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_a (
    .clk(clk), .reset(reset), .x(a_x), .y(a_y), .r(a_r), .g(a_g), .b(a_b),
    .VGA_R(a_R), .VGA_G(a_G), .VGA_B(a_B), .VGA_HS(a_hs), .VGA_VS(a_vs),
    .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn), .VGA_CLK(a_vc), .frame_start(a_fs));

  vga_scan_driver #(.CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_b (
    .clk(clk), .reset(reset), .x(b_x), .y(b_y), .r(b_r), .g(b_g), .b(b_b),
    .VGA_R(b_R), .VGA_G(b_G), .VGA_B(b_B), .VGA_HS(b_hs), .VGA_VS(b_vs),
    .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn), .VGA_CLK(b_vc), .frame_start(b_fs));

  vga_scan_driver dut_c (
    .clk(clk), .reset(reset), .x(c_x), .y(c_y), .r(c_r), .g(c_g), .b(c_b),
    .VGA_R(c_R), .VGA_G(c_G), .VGA_B(c_B), .VGA_HS(c_hs), .VGA_VS(c_vs),
    .VGA_BLANK_N(c_bn), .VGA_SYNC_N(c_sn), .VGA_CLK(c_vc), .frame_start(c_fs));

  // clk edges seen since the last reset release
  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else n <= n + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0h expected %0h", nm, n, act, exp);
    end
  endtask

  // Model: after n edges, T=n/D pixels have been ticked; the counters show
  // pixel T and the output stage shows pixel T-1.
  task automatic model_check(input string tag, input int D,
      input int HA, input int HF, input int HS, input int HB,
      input int VA, input int VF, input int VS, input int VB, input int sel,
      input logic [9:0] ax, input logic [8:0] ay,
      input logic [7:0] aR, input logic [7:0] aG, input logic [7:0] aB,
      input logic ahs, input logic avs, input logic abn, input logic asn,
      input logic avc, input logic afs);
    int ht, vt, t, h, v, q, hq, vq;
    bit act;
    logic [7:0] er, eg, eb;
    logic ehs, evs, ebn, efs, evc;
    ht = HA + HF + HS + HB;
    vt = VA + VF + VS + VB;
    t = n / D;
    h = t % ht;
    v = (t / ht) % vt;
    chk({tag, ".x"}, ax, (h < HA) ? h : HA - 1);
    chk({tag, ".y"}, ay, (v < VA) ? v : VA - 1);
    if (t == 0) begin
      er = 8'd0; eg = 8'd0; eb = 8'd0;
      ehs = 1'b1; evs = 1'b1; ebn = 1'b0; efs = 1'b0;
    end else begin
      q = t - 1;
      hq = q % ht;
      vq = (q / ht) % vt;
      act = (hq < HA) && (vq < VA);
      if (!act) begin
        er = 8'd0; eg = 8'd0; eb = 8'd0;
      end else if (sel == 1) begin
        er = 8'hFF; eg = 8'h00; eb = 8'((hq ^ vq) & 255);
      end else begin
        er = 8'(hq & 255); eg = 8'(vq & 255);
        eb = (sel == 0) ? 8'hC3 : 8'h5A;
      end
      ehs = !((hq >= HA + HF) && (hq < HA + HF + HS));
      evs = !((vq >= VA + VF) && (vq < VA + VF + VS));
      ebn = act;
      efs = ((n % D) == 0) && (hq == 0) && (vq == 0);
    end
    evc = (D == 1) ? 1'b1 : ((n % D) < (D / 2));
    chk({tag, ".VGA_R"}, aR, er);
    chk({tag, ".VGA_G"}, aG, eg);
    chk({tag, ".VGA_B"}, aB, eb);
    chk({tag, ".VGA_HS"}, ahs, ehs);
    chk({tag, ".VGA_VS"}, avs, evs);
    chk({tag, ".VGA_BLANK_N"}, abn, ebn);
    chk({tag, ".VGA_SYNC_N"}, asn, 1'b0);
    chk({tag, ".VGA_CLK"}, avc, evc);
    chk({tag, ".frame_start"}, afs, efs);
  endtask

  // Compare process: every negedge out of reset, all three instances vs model.
  always @(negedge clk) begin
    if (started && !reset) begin
      model_check("A", 2, 16, 2, 4, 3, 8, 2, 2, 3, 0, a_x, a_y, a_R, a_G, a_B,
                  a_hs, a_vs, a_bn, a_sn, a_vc, a_fs);
      model_check("B", 4, 16, 2, 4, 3, 8, 2, 2, 3, 1, b_x, b_y, b_R, b_G, b_B,
                  b_hs, b_vs, b_bn, b_sn, b_vc, b_fs);
      model_check("C", 2, 640, 16, 96, 48, 480, 10, 2, 33, 2, c_x, c_y, c_R, c_G, c_B,
                  c_hs, c_vs, c_bn, c_sn, c_vc, c_fs);
    end
  end

  // Snapshots for the hand-computed literal checks.
  int a_first = -1, a_second = -1, b_first = -1, b_second = -1, c_first = -1;
  logic c_hs_1312, c_hs_1314, c_hs_1504, c_hs_1506;
  logic [9:0] c_x_1400;
  logic [8:0] c_y_1400;
  logic [3:0] b_vc_pat;
  always @(negedge clk) begin
    if (phase1 && !reset) begin
      if (a_fs) begin
        if (a_first < 0) a_first <= n;
        else if (a_second < 0) a_second <= n;
      end
      if (b_fs) begin
        if (b_first < 0) b_first <= n;
        else if (b_second < 0) b_second <= n;
      end
      if (c_fs && c_first < 0) c_first <= n;
      if (n == 1312) c_hs_1312 <= c_hs;
      if (n == 1314) c_hs_1314 <= c_hs;
      if (n == 1504) c_hs_1504 <= c_hs;
      if (n == 1506) c_hs_1506 <= c_hs;
      if (n == 1400) begin
        c_x_1400 <= c_x;
        c_y_1400 <= c_y;
      end
      if (n >= 8 && n <= 11) b_vc_pat[n - 8] <= b_vc;
    end
  end

  initial begin
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    // reset-state literals
    chk("rst.x", a_x, 10'd0);
    chk("rst.y", a_y, 9'd0);
    chk("rst.VGA_R", a_R, 8'd0);
    chk("rst.VGA_HS", a_hs, 1'b1);
    chk("rst.VGA_VS", b_vs, 1'b1);
    chk("rst.VGA_BLANK_N", c_bn, 1'b0);
    chk("rst.frame_start", c_fs, 1'b0);
    chk("rst.VGA_CLK", b_vc, 1'b1);
    reset = 1'b0;
    started = 1'b1;
    phase1 = 1'b1;
    // A at n=3910: outputs show pixel 1954 -> h=4, v=3 of frame 5
    repeat (3910) @(negedge clk);
    phase1 = 1'b0;
    chk("A.mid.VGA_R", a_R, 8'd4);
    chk("A.mid.VGA_G", a_G, 8'd3);
    chk("A.mid.VGA_BLANK_N", a_bn, 1'b1);
    chk("A.first_fs", a_first, 2);
    chk("A.fs_period", a_second - a_first, 750);
    chk("B.first_fs", b_first, 4);
    chk("B.fs_period", b_second - b_first, 1500);
    chk("C.first_fs", c_first, 2);
    chk("C.x_at_h700", c_x_1400, 10'd639);
    chk("C.y_at_h700", c_y_1400, 9'd0);
    chk("C.hs_h655", c_hs_1312, 1'b1);
    chk("C.hs_h656", c_hs_1314, 1'b0);
    chk("C.hs_h751", c_hs_1504, 1'b0);
    chk("C.hs_h752", c_hs_1506, 1'b1);
    chk("B.vga_clk_pattern", b_vc_pat, 4'b0011);
    // asynchronous mid-frame reset
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst.x", a_x, 10'd0);
    chk("arst.y", a_y, 9'd0);
    chk("arst.VGA_R", a_R, 8'd0);
    chk("arst.VGA_G", a_G, 8'd0);
    chk("arst.VGA_BLANK_N", a_bn, 1'b0);
    chk("arst.VGA_HS", a_hs, 1'b1);
    chk("arst.C.x", c_x, 10'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (1700) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
